io_config_sequencer: RTL
========================

// Module: io_config_sequencer
// PURPOSE
//  Loads configuration bits into a daisy chain of NUM_IO IO_block instances.
//  Takes parallel words from a host over a valid/ready handshake and drives the
//  chain's serial bit_in, prgm_b and io_prgm_b controls. It then waits for the
//  last block's io_prgm_b_out (done token) and reports done or timeout error.
//  Sits between the bitstream loader and the IO ring.
// PARAMETERS
//  NUM_IO       4   IO blocks in the chain
//  BITS_PER_IO  16  config bits per block (8 switches x 2-bit enable_dir)
//  WORD_W       8   host word width; NUM_IO*BITS_PER_IO must be a multiple of WORD_W
//  TIMEOUT      64  max cycles to wait for the done token after the last bit
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  reset        in   1       synchronous, active-high
//  start        in   1       pulse: begin a config pass (ignored unless IDLE/ERROR)
//  cfg_data     in   WORD_W  config word; MSB is shifted first
//  cfg_valid    in   1       host word valid
//  cfg_ready    out  1       sequencer accepts word (valid&ready = transfer)
//  bit_in       out  1       serial config bit to chain head
//  prgm_b       out  1       global program enable, active-low
//  io_prgm_b    out  1       IO chain program enable, active-low
//  io_prgm_b_in out  1       shift strobe/token to chain head, active-low
//  chain_done_n in   1       io_prgm_b_out of last block, active-low = chain full
//  busy         out  1       high in every state except IDLE, ERROR
//  done         out  1       one-cycle pulse on successful completion
//  error        out  1       sticky timeout flag
// BEHAVIOUR
//  TOTAL = NUM_IO*BITS_PER_IO bits; NWORDS = TOTAL/WORD_W.
//  Reset / IDLE: cfg_ready=0, bit_in=0, prgm_b=1, io_prgm_b=1, io_prgm_b_in=1,
//   busy=0, done=0, error=0; all counters and the shift register are cleared.
//  FSM: IDLE -> START -> LOAD <-> SHIFT -> WAIT_DONE -> FINISH -> IDLE; WAIT_DONE -> ERROR.
//  IDLE: start=1 -> START. cfg_valid is ignored.
//  START (1 cycle): prgm_b=0, io_prgm_b=0; these stay 0 until FINISH/ERROR.
//  LOAD: cfg_ready=1, io_prgm_b_in=1, bit_in=0.
//   - cfg_valid=1: capture cfg_data into the shift register, clear bit_cnt, go to SHIFT.
//   - cfg_valid=0: stay in LOAD indefinitely; no timeout while waiting on the host.
//  SHIFT: cfg_ready=0, io_prgm_b_in=0, bit_in=sreg[WORD_W-1]; sreg shifts left by 1.
//   - Exactly WORD_W cycles per word; word_cnt increments on the last bit.
//   - Last bit with word_cnt==NWORDS-1 -> WAIT_DONE; otherwise -> LOAD.
//  Word throughput: WORD_W+1 cycles per word. Start to first cfg_ready is 2 cycles.
//  WAIT_DONE: io_prgm_b_in=1, bit_in=0; tmo_cnt increments each cycle.
//   - chain_done_n=0 -> FINISH. This takes priority if it coincides with the timeout.
//   - tmo_cnt==TIMEOUT-1 with chain_done_n=1 -> ERROR.
//  FINISH (1 cycle): done=1, prgm_b=1, io_prgm_b=1; next state IDLE.
//  ERROR: prgm_b=1, io_prgm_b=1, error=1 held; start=1 clears error and goes to START.
//  start is ignored while busy. A new pass always restarts from bit 0.
//  chain_done_n is ignored outside WAIT_DONE, including an early assertion.
//  reset asserted in any state: next edge restores the IDLE values above; partial
//   loads are discarded and prgm_b deasserts.
//  Counter widths: clog2(NWORDS+1), clog2(WORD_W+1), clog2(TIMEOUT+1). None wrap.
// TESTING
//  1 Defaults; words 8'hA5,8'h3C,8'hFF,8'h00 (first 4 of NWORDS=8) streamed at
//    valid=1; chain_done_n=0 two cycles after the last bit ->
//    bit_in = 1,0,1,0,0,1,0,1,... with io_prgm_b_in=0 on every bit cycle;
//    done pulses once; total start-to-done = 2+8*9+3 cycles.
//  2 Host stalls 5 cycles before word 3 -> cfg_ready held 1 for 5 cycles,
//    io_prgm_b_in=1, bit_in=0, no timeout; bit stream otherwise identical to test 1.
//  3 chain_done_n never asserts -> ERROR exactly TIMEOUT cycles after WAIT_DONE entry;
//    error=1, prgm_b=1, done never pulses.
//  4 From ERROR, pulse start -> error clears next cycle and a full pass completes normally.
//  5 reset during SHIFT of word 2 -> next cycle all outputs at IDLE values;
//    a following start reloads from word 0.
//  6 start pulsed mid-pass and chain_done_n=0 during SHIFT ->
//    both ignored; the pass completes unchanged.

Source files
------------

// File: rtl/io_config_sequencer.sv
// Serial configuration loader for a daisy chain of IO blocks: accepts host words,
// shifts them MSB-first into the chain, then waits for the chain's done token.
module io_config_sequencer #(
  parameter int NUM_IO      = 4,
  parameter int BITS_PER_IO = 16,
  parameter int WORD_W      = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              bit_in,
  output logic              prgm_b,
  output logic              io_prgm_b,
  output logic              io_prgm_b_in,
  input  logic              chain_done_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int TOTAL  = NUM_IO * BITS_PER_IO;
  localparam int NWORDS = TOTAL / WORD_W;
  localparam int WC_W   = $clog2(NWORDS + 1);
  localparam int BC_W   = $clog2(WORD_W + 1);
  localparam int TC_W   = $clog2(TIMEOUT + 1);

  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NWORDS - 1);
  localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(WORD_W - 1);
  localparam logic [TC_W-1:0] LAST_TMO  = TC_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD,
    S_SHIFT,
    S_WAIT_DONE,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t            state, state_next;
  logic [WORD_W-1:0] sreg;
  logic [BC_W-1:0]   bit_cnt;
  logic [WC_W-1:0]   word_cnt;
  logic [TC_W-1:0]   tmo_cnt;
  logic              last_bit;

  assign last_bit = (bit_cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      sreg     <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      state <= state_next;
      case (state)
        // every pass restarts from bit 0 regardless of how the last one ended
        S_START: begin
          sreg     <= '0;
          bit_cnt  <= '0;
          word_cnt <= '0;
          tmo_cnt  <= '0;
        end
        S_LOAD: begin
          if (cfg_valid) begin
            sreg    <= cfg_data;
            bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          sreg <= {sreg[WORD_W-2:0], 1'b0};
          if (last_bit) begin
            bit_cnt  <= '0;
            word_cnt <= word_cnt + WC_W'(1);
          end else begin
            bit_cnt <= bit_cnt + BC_W'(1);
          end
        end
        S_WAIT_DONE: tmo_cnt <= tmo_cnt + TC_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next   = state;
    cfg_ready    = 1'b0;
    bit_in       = 1'b0;
    prgm_b       = 1'b1;
    io_prgm_b    = 1'b1;
    io_prgm_b_in = 1'b1;
    busy         = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_START;
      end
      S_START: begin
        prgm_b     = 1'b0;
        io_prgm_b  = 1'b0;
        state_next = S_LOAD;
      end
      S_LOAD: begin
        prgm_b    = 1'b0;
        io_prgm_b = 1'b0;
        cfg_ready = 1'b1;
        if (cfg_valid) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        prgm_b       = 1'b0;
        io_prgm_b    = 1'b0;
        io_prgm_b_in = 1'b0;
        bit_in       = sreg[WORD_W-1];
        if (last_bit) state_next = (word_cnt == LAST_WORD) ? S_WAIT_DONE : S_LOAD;
      end
      S_WAIT_DONE: begin
        prgm_b    = 1'b0;
        io_prgm_b = 1'b0;
        // the done token wins over a timeout landing in the same cycle
        if (!chain_done_n)           state_next = S_FINISH;
        else if (tmo_cnt == LAST_TMO) state_next = S_ERROR;
      end
      S_FINISH: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_ERROR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (start) state_next = S_START;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
